// File: rtl/elevator_call_scheduler.sv
// Call scheduler and cabin sequencer for a 4-floor elevator (G..F3).
// Latches calls, serves them in SCAN order, drives motor/door, handles overload and fire recall.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   cab_btn, hall_req     per-floor call inputs (bit i = floor i)
//   overload, firealarm   cabin overweight hold, fire recall request
//   cur_floor             current / last-passed floor
//   moving_up/down        motor commands
//   door_open/closed      door command and its complement
//   dir_up                SCAN direction
//   pending               latched unserved calls
module elevator_call_scheduler #(
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cab_btn,
    input  logic [3:0] hall_req,
    input  logic       overload,
    input  logic       firealarm,
    output logic [1:0] cur_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       door_closed,
    output logic       dir_up,
    output logic [3:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR,
        FIRE_MOVE,
        FIRE_DOOR
    } state_t;

    state_t        state;
    logic          fire_act;
    logic [TW-1:0] travel_cnt;
    logic [DW-1:0] door_cnt;

    logic [3:0] req;
    logic [3:0] cur_hot;
    logic [3:0] next_hot;
    logic [3:0] latch_req;
    logic [3:0] pend_next;
    logic [1:0] next_floor;
    logic       fire_mode;
    logic       same_press;
    logic       calls_above;
    logic       calls_below;
    logic       stop_here;

    always_comb begin
        req        = cab_btn | hall_req;
        cur_hot    = 4'b0001 << cur_floor;
        next_floor = (state == MOVE_UP) ? cur_floor + 2'd1 : cur_floor - 2'd1;
        next_hot   = 4'b0001 << next_floor;
        // fire_act keeps latching blocked for the whole recall, even after the alarm drops
        fire_mode  = firealarm | fire_act;
        // a press for the open-door floor only extends the dwell
        latch_req  = fire_mode ? 4'b0000 : (door_open ? (req & ~cur_hot) : req);
        same_press = ~fire_mode & door_open & (|(req & cur_hot));
        pend_next  = pending | latch_req;
        calls_above = |(pending & ~((cur_hot << 1) - 4'd1));
        calls_below = |(pending & (cur_hot - 4'd1));
        // include same-cycle presses so the clear also swallows them
        stop_here  = |(pend_next & next_hot);
    end

    assign door_closed = ~door_open;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur_floor   <= 2'd0;
            dir_up      <= 1'b1;
            pending     <= 4'b0000;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            fire_act    <= 1'b0;
            travel_cnt  <= '0;
            door_cnt    <= '0;
        end else begin
            pending <= firealarm ? 4'b0000 : pend_next;
            if (firealarm)
                fire_act <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (firealarm) begin
                        dir_up <= 1'b0;
                        if (cur_floor == 2'd0) begin
                            state     <= FIRE_DOOR;
                            door_open <= 1'b1;
                        end else begin
                            state       <= FIRE_MOVE;
                            moving_down <= 1'b1;
                            travel_cnt  <= TRAVEL_LOAD;
                        end
                    end else if (pending[cur_floor] | overload) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_cnt  <= DOOR_LOAD;
                        pending   <= pend_next & ~cur_hot;
                    end else if (dir_up && calls_above) begin
                        state      <= MOVE_UP;
                        moving_up  <= 1'b1;
                        travel_cnt <= TRAVEL_LOAD;
                    end else if (calls_below) begin
                        state       <= MOVE_DOWN;
                        moving_down <= 1'b1;
                        dir_up      <= 1'b0;
                        travel_cnt  <= TRAVEL_LOAD;
                    end else if (calls_above) begin
                        state      <= MOVE_UP;
                        moving_up  <= 1'b1;
                        dir_up     <= 1'b1;
                        travel_cnt <= TRAVEL_LOAD;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - TW'(1);
                    end else begin
                        cur_floor <= next_floor;
                        if (fire_mode) begin
                            // step finished; recall heads straight for G
                            moving_up <= 1'b0;
                            dir_up    <= 1'b0;
                            if (next_floor == 2'd0) begin
                                state       <= FIRE_DOOR;
                                moving_down <= 1'b0;
                                door_open   <= 1'b1;
                            end else begin
                                state       <= FIRE_MOVE;
                                moving_down <= 1'b1;
                                travel_cnt  <= TRAVEL_LOAD;
                            end
                        end else if (stop_here) begin
                            state       <= DOOR;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                            door_open   <= 1'b1;
                            door_cnt    <= DOOR_LOAD;
                            pending     <= pend_next & ~next_hot;
                        end else if (next_floor == 2'd0 || next_floor == 2'd3) begin
                            // end of shaft with nothing to serve: never run past it
                            state       <= IDLE;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                        end else begin
                            travel_cnt <= TRAVEL_LOAD;
                        end
                    end
                end
                DOOR: begin
                    if (firealarm) begin
                        dir_up <= 1'b0;
                        if (cur_floor == 2'd0) begin
                            state <= FIRE_DOOR;
                        end else begin
                            state       <= FIRE_MOVE;
                            door_open   <= 1'b0;
                            moving_down <= 1'b1;
                            travel_cnt  <= TRAVEL_LOAD;
                        end
                    end else if (overload | same_press) begin
                        door_cnt <= DOOR_LOAD;
                    end else if (door_cnt != '0) begin
                        door_cnt <= door_cnt - DW'(1);
                    end else begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end
                end
                FIRE_MOVE: begin
                    if (travel_cnt != '0) begin
                        travel_cnt <= travel_cnt - TW'(1);
                    end else begin
                        cur_floor <= next_floor;
                        if (next_floor == 2'd0) begin
                            state       <= FIRE_DOOR;
                            moving_down <= 1'b0;
                            door_open   <= 1'b1;
                        end else begin
                            travel_cnt <= TRAVEL_LOAD;
                        end
                    end
                end
                FIRE_DOOR: begin
                    if (!firealarm) begin
                        state    <= DOOR;
                        door_cnt <= DOOR_LOAD;
                        fire_act <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed testbench for elevator_call_scheduler.
// Vector table for normal SCAN service plus hand sequences for overload, fire, reset and dwell reload.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cab_btn;
    logic [3:0] hall_req;
    logic       overload;
    logic       firealarm;
    logic [1:0] cur_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       door_closed;
    logic       dir_up;
    logic [3:0] pending;

    int checks = 0;
    int failures = 0;

    elevator_call_scheduler #(
        .TRAVEL_CYCLES(3),
        .DOOR_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cab_btn    (cab_btn),
        .hall_req   (hall_req),
        .overload   (overload),
        .firealarm  (firealarm),
        .cur_floor  (cur_floor),
        .moving_up  (moving_up),
        .moving_down(moving_down),
        .door_open  (door_open),
        .door_closed(door_closed),
        .dir_up     (dir_up),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // {floor, up, down, door, dir_up, pending}
    typedef struct {
        logic [3:0] cab;
        logic [3:0] hall;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] obs();
        return {cur_floor, moving_up, moving_down, door_open, dir_up, pending};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("exclusive", 32'($countones({moving_up, moving_down, door_open}) > 1), 32'd0);
        chk("door_closed", 32'(door_closed), door_open ? 32'd0 : 32'd1);
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] h, input logic o, input logic f);
        cab_btn   = c;
        hall_req  = h;
        overload  = o;
        firealarm = f;
    endtask

    task automatic add(input int n, input logic [3:0] c, input logic [3:0] h,
                       input logic [1:0] fl, input logic mu, input logic md,
                       input logic dr, input logic dir, input logic [3:0] pd);
        vec_t v;
        v.cab  = c;
        v.hall = h;
        v.exp  = {fl, mu, md, dr, dir, pd};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic wait_door(input string name);
        int n = 0;
        while (!door_open && n < 30) begin
            tick();
            n++;
        end
        chk(name, 32'(door_open), 32'd1);
    endtask

    task automatic wait_closed(input string name);
        int n = 0;
        while (door_open && n < 30) begin
            tick();
            n++;
        end
        chk(name, 32'(door_open), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // go to F2, then F3 and back down to G
        add(1, 4'b0100, 4'b0000, 2'd0, 0, 0, 0, 1, 4'b0100);
        add(3, 4'b0000, 4'b0000, 2'd0, 1, 0, 0, 1, 4'b0100);
        add(3, 4'b0000, 4'b0000, 2'd1, 1, 0, 0, 1, 4'b0100);
        add(4, 4'b0000, 4'b0000, 2'd2, 0, 0, 1, 1, 4'b0000);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 1, 4'b0000);
        add(1, 4'b1000, 4'b0001, 2'd2, 0, 0, 0, 1, 4'b1001);
        add(3, 4'b0000, 4'b0000, 2'd2, 1, 0, 0, 1, 4'b1001);
        add(4, 4'b0000, 4'b0000, 2'd3, 0, 0, 1, 1, 4'b0001);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 0, 0, 1, 4'b0001);
        add(3, 4'b0000, 4'b0000, 2'd3, 0, 1, 0, 0, 4'b0001);
        add(3, 4'b0000, 4'b0000, 2'd2, 0, 1, 0, 0, 4'b0001);
        add(3, 4'b0000, 4'b0000, 2'd1, 0, 1, 0, 0, 4'b0001);
        add(4, 4'b0000, 4'b0000, 2'd0, 0, 0, 1, 0, 4'b0000);
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 0, 4'b0000);

        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_state", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000}));
        chk("reset_closed", 32'(door_closed), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cab, vecs[i].hall, 1'b0, 1'b0);
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);

        // overload hold at F1 with a queued call for F3
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        wait_door("t3_arrive1");
        chk("t3_floor1", 32'(cur_floor), 32'd1);
        drive(4'b1000, 4'b0000, 1'b1, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t3_hold", 32'(door_open), 32'd1);
        end
        chk("t3_queued", 32'(pending), 32'b1000);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_dwell", 32'({door_open, moving_up}), 32'b10);
        end
        tick();
        chk("t3_closed", 32'({door_open, moving_up}), 32'b00);
        tick();
        chk("t3_depart", 32'(moving_up), 32'd1);
        wait_door("t3_arrive3");
        chk("t3_floor3", 32'({cur_floor, pending}), 32'({2'd3, 4'b0000}));
        wait_closed("t3_idle");

        // async reset while descending from F3
        drive(4'b0000, 4'b0001, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        chk("t5_moving", 32'(moving_down), 32'd1);
        tick();
        #3;
        reset = 1'b1;
        #1;
        chk("t5_async", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000}));
        chk("t5_closed", 32'(door_closed), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_quiet", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000}));
        end

        // fire recall while travelling F1 -> F2
        drive(4'b1100, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("t4_latch", 32'(pending), 32'b1100);
        n = 0;
        while (cur_floor != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_at1", 32'({cur_floor, moving_up}), 32'b011);
        drive(4'b0010, 4'b0000, 1'b0, 1'b1);
        tick();
        chk("t4_clear", 32'({pending, moving_up, cur_floor}), 32'({4'b0000, 1'b1, 2'd1}));
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        tick();
        chk("t4_at2", 32'(obs()), 32'({2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000}));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_nostop", 32'({door_open, moving_down}), 32'b01);
        end
        tick();
        chk("t4_at0", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}));
        drive(4'b0010, 4'b0000, 1'b0, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        tick();
        chk("t4_held", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_dwell", 32'(door_open), 32'd1);
        end
        tick();
        chk("t4_closed", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));
        tick();
        tick();
        chk("t4_idle", 32'(obs()), 32'({2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000}));

        // same-floor presses extend the dwell at F2
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        wait_door("t6_arrive");
        chk("t6_floor", 32'({cur_floor, pending, dir_up}), 32'({2'd2, 4'b0000, 1'b1}));
        tick();
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("t6_reload1", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("t6_reload2", 32'({door_open, pending}), 32'({1'b1, 4'b0000}));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_dwell", 32'(door_open), 32'd1);
        end
        tick();
        chk("t6_closed", 32'({door_open, pending}), 32'({1'b0, 4'b0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
